// File: rtl/exdata_cnt_pkg.sv
// Shared definitions for the exdata multi-channel counter bank.
// Contents:
//   SPILL_CNT_W  width of the spill counter
//   N_CH_DEF     default channel count
//   CNT_W_DEF    default counter/snapshot width
//   edge_t       classification of the live gate in the current cycle
//   classify_edge  maps (live, pre_live) onto edge_t
package exdata_cnt_pkg;

    localparam int SPILL_CNT_W = 16;
    localparam int N_CH_DEF    = 4;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_t;

    function automatic edge_t classify_edge(input logic live, input logic pre_live);
        if (live && !pre_live) begin
            return EDGE_RISE;
        end
        if (!live && pre_live) begin
            return EDGE_FALL;
        end
        return EDGE_NONE;
    endfunction

endpackage

// File: rtl/exdata_cnt_ch.sv
// One channel of the exdata counter bank: live counter, sticky overflow
// flag and end-of-spill snapshot register.
// Build option: EXDATA_CNT_SAT_EN defined -> counter saturates at all-ones,
// otherwise it wraps to zero. The overflow flag is set in both builds.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   edge_kind  live gate edge in this cycle (from the bank top)
//   live       spill gate level
//   in_bit     count enable for this channel
//   cnt        current counter value
//   ovf        overflow seen during the current spill
//   snap       counter value frozen at the last spill end
module exdata_cnt_ch
    import exdata_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  edge_t            edge_kind,
    input  logic             live,
    input  logic             in_bit,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic [CNT_W-1:0] snap
);

    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] snap_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            ovf_reg  <= 1'b0;
            snap_reg <= '0;
        end else begin
            if (edge_kind == EDGE_RISE) begin
                // Spill start: clear and count the first pulse in the same cycle.
                cnt_reg <= {{(CNT_W-1){1'b0}}, in_bit};
                ovf_reg <= 1'b0;
            end else if (live && in_bit) begin
                if (&cnt_reg) begin
                    ovf_reg <= 1'b1;
`ifdef EXDATA_CNT_SAT_EN
                    cnt_reg <= cnt_reg;
`else
                    cnt_reg <= '0;
`endif
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            // On the fall cycle live is already 0, so cnt_reg is stable here.
            if (edge_kind == EDGE_FALL) begin
                snap_reg <= cnt_reg;
            end
        end
    end

    assign cnt  = cnt_reg;
    assign ovf  = ovf_reg;
    assign snap = snap_reg;

endmodule

// File: rtl/exdata_cnt_bank.sv
// Multi-channel per-spill event counter bank.
// Counts in[i] pulses while live is high, clears all channels at spill
// start (live rising edge) and freezes a per-channel snapshot at spill end
// (live falling edge). Snapshots are read back by channel index.
// Build option: EXDATA_CNT_SAT_EN (saturating counters; default wraps).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in          per-channel count enables
//   live        spill gate (level)
//   cnt         live counters, channel i at [i*CNT_W +: CNT_W]
//   snap_valid  one-cycle pulse after a snapshot update
//   spill_cnt   number of spill starts since reset (wraps)
//   ovf         per-channel overflow flags for the current spill
//   rd_sel      snapshot channel select
//   rd_data     registered snapshot of channel rd_sel (0 if out of range)
module exdata_cnt_bank
    import exdata_cnt_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        in,
    input  logic                   live,
    output logic [N_CH*CNT_W-1:0]  cnt,
    output logic                   snap_valid,
    output logic [SPILL_CNT_W-1:0] spill_cnt,
    output logic [N_CH-1:0]        ovf,
    input  logic [SEL_W-1:0]       rd_sel,
    output logic [CNT_W-1:0]       rd_data
);

    logic                   pre_live_reg;
    edge_t                  edge_kind;
    logic                   rd_in_range;
    logic [CNT_W-1:0]       cnt_arr  [N_CH];
    logic [CNT_W-1:0]       snap_arr [N_CH];
    logic [SPILL_CNT_W-1:0] spill_cnt_reg;
    logic                   snap_valid_reg;
    logic [CNT_W-1:0]       rd_data_reg;

    assign edge_kind   = classify_edge(live, pre_live_reg);
    assign rd_in_range = (32'(rd_sel) < 32'(N_CH));

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        exdata_cnt_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .edge_kind (edge_kind),
            .live      (live),
            .in_bit    (in[gi]),
            .cnt       (cnt_arr[gi]),
            .ovf       (ovf[gi]),
            .snap      (snap_arr[gi])
        );
        assign cnt[gi*CNT_W +: CNT_W] = cnt_arr[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_live_reg   <= 1'b0;
            spill_cnt_reg  <= '0;
            snap_valid_reg <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            pre_live_reg   <= live;
            snap_valid_reg <= (edge_kind == EDGE_FALL);
            if (edge_kind == EDGE_RISE) begin
                spill_cnt_reg <= spill_cnt_reg + 1'b1;
            end
            // On the fall cycle the snapshot is being written from cnt, so
            // read the counter directly; rd_data then matches the new
            // snapshot in the same cycle snap_valid is asserted.
            if (!rd_in_range) begin
                rd_data_reg <= '0;
            end else if (edge_kind == EDGE_FALL) begin
                rd_data_reg <= cnt_arr[rd_sel];
            end else begin
                rd_data_reg <= snap_arr[rd_sel];
            end
        end
    end

    assign spill_cnt  = spill_cnt_reg;
    assign snap_valid = snap_valid_reg;
    assign rd_data    = rd_data_reg;

endmodule
